// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Converts single CPU load/store requests (byte, half, word) into accesses
//   on a word-wide, one-cycle-latency data memory. Sub-word stores become a
//   read-modify-write. Misaligned or illegal-size requests get an immediate
//   error response and never touch the memory.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake (ready only while idle)
//   req_write, req_addr,      store flag, byte address, store data,
//   req_wdata, req_size,      size (00 byte, 01 half, 10 word, 11 illegal),
//   req_zext                  load zero-extend (1) / sign-extend (0)
//   resp_valid, resp_rdata,   one-cycle completion pulse, extended load data,
//   resp_err                  error flag qualified by resp_valid
//   mem_addr, mem_re, mem_we, word address and strobes to the memory,
//   mem_wdata, mem_rdata      write word, read word (valid one cycle after mem_re)
module mem_access_sequencer #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_zext,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic              wr_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [1:0]        boff_r;
    logic [1:0]        size_r;
    logic              zext_r;
    logic              err_r;
    logic [DATA_W-1:0] wdata_r;   // store data, later the merged word
    logic [DATA_W-1:0] rdata_r;   // extended load data, 0 for stores/errors
    logic              req_illegal;
    logic              accept;
    logic              unused_addr_hi;

    // Byte-address bits above the memory window do not select anything.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign accept = req_valid && (state == IDLE);

    assign req_illegal = (req_size == 2'b11)
                      || ((req_size == 2'b01) && req_addr[0])
                      || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Pick the addressed field out of a memory word and extend it to 32 bits.
    function automatic logic [DATA_W-1:0] extract_load(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        off,
        input logic [1:0]        size,
        input logic              zext
    );
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [DATA_W-1:0] ext;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00: begin
                if (zext) ext = {24'd0, b};
                else      ext = 32'(b);
            end
            2'b01: begin
                if (zext) ext = {16'd0, h};
                else      ext = 32'(h);
            end
            default: ext = word;
        endcase
        return ext;
    endfunction

    // Overwrite only the addressed byte/half lane, keeping every other bit.
    function automatic logic [DATA_W-1:0] merge_store(
        input logic [DATA_W-1:0] word,
        input logic [DATA_W-1:0] wdata,
        input logic [1:0]        off,
        input logic [1:0]        size
    );
        logic [DATA_W-1:0] r;
        r = word;
        if (size == 2'b00) r[{off, 3'b000} +: 8]     = wdata[7:0];
        else               r[{off[1], 4'b0000} +: 16] = wdata[15:0];
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_illegal)             state_nxt = RESP;
                    else if (!req_write)         state_nxt = READ;
                    else if (req_size == 2'b10)  state_nxt = WRITE;
                    else                         state_nxt = READ;
                end
            end
            READ:    state_nxt = MERGE;
            MERGE:   state_nxt = wr_r ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and merge datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_r    <= 1'b0;
            waddr_r <= '0;
            boff_r  <= 2'b00;
            size_r  <= 2'b00;
            zext_r  <= 1'b0;
            err_r   <= 1'b0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else if (accept) begin
            wr_r    <= req_write;
            waddr_r <= req_addr[ADDR_W+1:2];
            boff_r  <= req_addr[1:0];
            size_r  <= req_size;
            zext_r  <= req_zext;
            err_r   <= req_illegal;
            wdata_r <= req_wdata;
            rdata_r <= '0;
        end else if (state == MERGE) begin
            // mem_rdata is valid here, one cycle after the READ strobe.
            if (wr_r) wdata_r <= merge_store(mem_rdata, wdata_r, boff_r, size_r);
            else      rdata_r <= extract_load(mem_rdata, boff_r, size_r, zext_r);
        end
    end

    // Outputs
    always_comb begin
        req_ready  = (state == IDLE);
        mem_re     = (state == READ);
        mem_we     = (state == WRITE);
        mem_wdata  = (state == WRITE) ? wdata_r : '0;
        mem_addr   = waddr_r;
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_r;
        resp_rdata = (state == RESP) ? rdata_r : '0;
    end

endmodule
